// File: rtl/team_10_wb_master.sv
// team_10_wb_master
//
// Wishbone classic single-transfer bus master. User logic hands over one
// request (read or write) on a valid/ready channel. The block runs it on the
// Wishbone master port and returns the result on a second valid/ready
// channel. Only one transfer is outstanding at a time. A transfer that the
// slave never acknowledges is aborted after TIMEOUT_CYCLES strobe cycles and
// reported with rsp_err=1.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of strobe cycles without ACK_I before the
//                    transfer is aborted. 0 disables the timeout.
//
// Ports
//   clk_i, nrst          : clock and asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_we               : 1 = write, 0 = read
//   req_adr              : byte address, passed through unmodified
//   req_dat              : write data
//   req_sel              : byte selects
//   rsp_valid/rsp_ready  : response handshake
//   rsp_dat              : read data (0 for writes and timeouts)
//   rsp_err              : 1 = transfer aborted by timeout
//   ADR_O, DAT_O, SEL_O,
//   WE_O, STB_O, CYC_O   : registered Wishbone master outputs
//   DAT_I, ACK_I         : Wishbone master inputs
module team_10_wb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        nrst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The counter holds the number of strobe cycles already completed, so the
    // abort decision is taken in the cycle where it equals TIMEOUT_CYCLES-1;
    // that makes the strobe last exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Registered bus cycle flag; CYC_O and STB_O are identical for a
    // single-transfer classic master.
    logic              bus_q, bus_d;
    logic [31:0]       adr_d, dat_d, rdat_d;
    logic [3:0]        sel_d;
    logic              we_d, rvld_d, rerr_d;
    logic              timeout_hit;

    // req_ready is gated by nrst so it reads 0 while reset is asserted and
    // 1 immediately after release.
    assign req_ready = (state_q == IDLE) && nrst;
    assign STB_O     = bus_q;
    assign CYC_O     = bus_q;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        adr_d       = ADR_O;
        dat_d       = DAT_O;
        sel_d       = SEL_O;
        we_d        = WE_O;
        rvld_d      = rsp_valid;
        rdat_d      = rsp_dat;
        rerr_d      = rsp_err;
        timeout_hit = TO_EN && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = BUS;
                    cnt_d   = '0;
                    bus_d   = 1'b1;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    sel_d   = req_sel;
                    we_d    = req_we;
                end
            end

            BUS: begin
                // ACK has priority over a timeout falling in the same cycle.
                if (ACK_I || timeout_hit) begin
                    state_d = RESP;
                    bus_d   = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    rvld_d  = 1'b1;
                    if (ACK_I) begin
                        rdat_d = WE_O ? 32'h0 : DAT_I;
                        rerr_d = 1'b0;
                    end else begin
                        rdat_d = 32'h0;
                        rerr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rvld_d  = 1'b0;
                    rdat_d  = 32'h0;
                    rerr_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                bus_d   = 1'b0;
                adr_d   = '0;
                dat_d   = '0;
                sel_d   = '0;
                we_d    = 1'b0;
                rvld_d  = 1'b0;
                rdat_d  = 32'h0;
                rerr_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_q     <= 1'b0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            ADR_O     <= adr_d;
            DAT_O     <= dat_d;
            SEL_O     <= sel_d;
            WE_O      <= we_d;
            rsp_valid <= rvld_d;
            rsp_dat   <= rdat_d;
            rsp_err   <= rerr_d;
        end
    end

endmodule
